// File: rtl/shift_sequencer.sv
// Multi-cycle shift unit: SLL/SRL/SRA/ROL, one bit position per clock,
// with a Start/Busy/Done handshake towards the ALU control FSM.
module shift_sequencer #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned SHAMT_W = 4
) (
  input  logic               Clock,
  input  logic               ResetN,
  input  logic               Start,
  input  logic               Abort,
  input  logic [1:0]         Op,
  input  logic [WIDTH-1:0]   A,
  input  logic [SHAMT_W-1:0] Shamt,
  output logic               Busy,
  output logic               Done,
  output logic [WIDTH-1:0]   Result
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROL = 2'b11;

  logic [1:0]         state_q, state_nxt;
  logic [WIDTH-1:0]   work_q, work_nxt;
  logic [SHAMT_W-1:0] count_q, count_nxt;
  logic [1:0]         op_q, op_nxt;
  logic [WIDTH-1:0]   result_nxt;
  logic [WIDTH-1:0]   step_c;

  // One-bit step of the working register for the captured operation
  always_comb begin
    step_c = work_q;
    case (op_q)
      OP_SLL:  step_c = {work_q[WIDTH-2:0], 1'b0};
      OP_SRL:  step_c = {1'b0, work_q[WIDTH-1:1]};
      OP_SRA:  step_c = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
      OP_ROL:  step_c = {work_q[WIDTH-2:0], work_q[WIDTH-1]};
      default: step_c = work_q;
    endcase
  end

  // Next-state and datapath update; Abort always wins over Start
  always_comb begin
    state_nxt  = state_q;
    work_nxt   = work_q;
    count_nxt  = count_q;
    op_nxt     = op_q;
    result_nxt = Result;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (Start && !Abort) begin
          work_nxt  = A;
          op_nxt    = Op;
          count_nxt = Shamt;
          if (Shamt == '0) begin
            result_nxt = A;
            state_nxt  = ST_DONE;
          end else begin
            state_nxt  = ST_SHIFT;
          end
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (Abort) begin
          state_nxt = ST_IDLE;
        end else if (count_q == SHAMT_W'(1)) begin
          result_nxt = step_c;
          state_nxt  = ST_DONE;
        end else begin
          work_nxt  = step_c;
          count_nxt = count_q - SHAMT_W'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, datapath and registered handshake outputs
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q <= ST_IDLE;
      work_q  <= '0;
      count_q <= '0;
      op_q    <= OP_SLL;
      Result  <= '0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
    end else begin
      state_q <= state_nxt;
      work_q  <= work_nxt;
      count_q <= count_nxt;
      op_q    <= op_nxt;
      Result  <= result_nxt;
      Busy    <= (state_nxt == ST_SHIFT);
      Done    <= (state_nxt == ST_DONE);
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed self-checking bench for shift_sequencer.
module tb_shift_sequencer;

  logic        Clock;
  logic        ResetN;
  logic        Start;
  logic        Abort;
  logic [1:0]  Op;
  logic [15:0] A;
  logic [3:0]  Shamt;
  logic        Busy;
  logic        Done;
  logic [15:0] Result;

  int checks;
  int failures;

  shift_sequencer #(.WIDTH(16), .SHAMT_W(4)) dut (
    .Clock  (Clock),
    .ResetN (ResetN),
    .Start  (Start),
    .Abort  (Abort),
    .Op     (Op),
    .A      (A),
    .Shamt  (Shamt),
    .Busy   (Busy),
    .Done   (Done),
    .Result (Result)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Issue one operation and follow it to its Done cycle (returns in that cycle)
  task automatic run_op(input string tag, input logic [1:0] op, input logic [15:0] a,
                        input logic [3:0] sh, input logic [15:0] exp);
    Start = 1'b1; Op = op; A = a; Shamt = sh;
    tick();
    Start = 1'b0; Op = 2'b00; A = 16'h0; Shamt = 4'h0;
    for (int i = 0; i < int'(sh); i++) begin
      check({tag, "_busy"}, 32'(Busy), 32'd1);
      check({tag, "_nodone"}, 32'(Done), 32'd0);
      tick();
    end
    check({tag, "_done"}, 32'(Done), 32'd1);
    check({tag, "_busy_low"}, 32'(Busy), 32'd0);
    check({tag, "_result"}, 32'(Result), 32'(exp));
  endtask

  initial begin
    checks = 0; failures = 0;
    ResetN = 1'b0; Start = 1'b0; Abort = 1'b0; Op = 2'b00; A = 16'h0; Shamt = 4'h0;
    #1;
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_result", 32'(Result), 32'd0);
    tick(); tick();
    #2 ResetN = 1'b1;
    tick();
    check("idle_busy", 32'(Busy), 32'd0);

    run_op("sll4", 2'b00, 16'h00F1, 4'd4, 16'h0F10);
    tick();
    check("sll4_pulse", 32'(Done), 32'd0);

    run_op("sra15", 2'b10, 16'h8001, 4'd15, 16'hFFFF);
    tick();
    run_op("srl15", 2'b01, 16'h8001, 4'd15, 16'h0001);
    tick();
    run_op("rol1", 2'b11, 16'h8001, 4'd1, 16'h0003);
    tick();
    run_op("zero", 2'b10, 16'h1234, 4'd0, 16'h1234);
    tick();
    check("zero_pulse", 32'(Done), 32'd0);

    // Start together with Abort in IDLE: nothing captured
    Start = 1'b1; Abort = 1'b1; A = 16'h5555; Shamt = 4'd0;
    tick();
    Start = 1'b0; Abort = 1'b0;
    check("sa_done", 32'(Done), 32'd0);
    check("sa_busy", 32'(Busy), 32'd0);
    check("sa_result", 32'(Result), 32'h1234);
    tick();
    check("sa_idle", 32'(Done), 32'd0);

    // Abort in the third SHIFT cycle
    Start = 1'b1; Op = 2'b00; A = 16'h0001; Shamt = 4'd8;
    tick();
    Start = 1'b0;
    check("ab_busy1", 32'(Busy), 32'd1);
    tick();
    check("ab_busy2", 32'(Busy), 32'd1);
    tick();
    check("ab_busy3", 32'(Busy), 32'd1);
    Abort = 1'b1;
    tick();
    Abort = 1'b0;
    check("ab_busy_drop", 32'(Busy), 32'd0);
    check("ab_nodone", 32'(Done), 32'd0);
    check("ab_result", 32'(Result), 32'h1234);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("ab_nodone_late", 32'(Done), 32'd0);
    end

    // Start during SHIFT ignored, then back-to-back Start in DONE
    Start = 1'b1; Op = 2'b00; A = 16'h0003; Shamt = 4'd3;
    tick();
    Op = 2'b01; A = 16'hFFFF; Shamt = 4'd1;
    check("ign_busy1", 32'(Busy), 32'd1);
    tick();
    check("ign_busy2", 32'(Busy), 32'd1);
    tick();
    Start = 1'b0;
    check("ign_busy3", 32'(Busy), 32'd1);
    tick();
    check("ign_done", 32'(Done), 32'd1);
    check("ign_result", 32'(Result), 32'h0018);
    Start = 1'b1; Op = 2'b01; A = 16'hF000; Shamt = 4'd4;
    tick();
    Start = 1'b0;
    check("b2b_pulse", 32'(Done), 32'd0);
    check("b2b_hold", 32'(Result), 32'h0018);
    for (int i = 0; i < 4; i++) begin
      check("b2b_busy", 32'(Busy), 32'd1);
      tick();
    end
    check("b2b_done", 32'(Done), 32'd1);
    check("b2b_result", 32'(Result), 32'h0F00);
    tick();

    // Asynchronous reset in the middle of a SHIFT sequence
    Start = 1'b1; Op = 2'b00; A = 16'h0001; Shamt = 4'd8;
    tick();
    Start = 1'b0;
    tick();
    check("ar_pre_busy", 32'(Busy), 32'd1);
    #3 ResetN = 1'b0;
    #1;
    check("ar_busy", 32'(Busy), 32'd0);
    check("ar_done", 32'(Done), 32'd0);
    check("ar_result", 32'(Result), 32'd0);
    tick();
    #2 ResetN = 1'b1;
    tick();
    check("ar_post_busy", 32'(Busy), 32'd0);
    check("ar_post_done", 32'(Done), 32'd0);
    run_op("post", 2'b00, 16'h0003, 4'd2, 16'h000C);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
